spi_master: RTL and testbench

- SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one DATA_WIDTH-bit word per transaction.
- Drives ss/sck/mosi into the existing spiSlave block and samples its miso.
- A local controller issues a start pulse with a parallel word and gets back the received word plus a one-cycle done pulse.
- sck is generated from clk by an integer divider; spiSlave oversamples sck with the same clk.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master.sv | 155 +++++++++++++++
 tb/tb_spi_master.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the spiSlave block.
// Holds the controller state encoding, the default word width, the smallest
// usable sck divider, and the SPI mode this link runs in (mode 0).
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    GAP
  } spi_state_e;

  localparam int SPI_DATA_WIDTH  = 8;
  localparam int SPI_MIN_CLK_DIV = 2;

  // Mode 0: sck idles low, data sampled on the rising sck edge.
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_div.sv
// sck phase divider: counts clk cycles and pulses o_tick on the cycle that
// completes CLK_DIV cycles since the last wrap or clear.
// Ports:
//   clk     system clock
//   rst     async active-low reset
//   i_clr   hold the count at 0 (keeps every state entry phase-aligned)
//   o_tick  combinational, high while the count sits at CLK_DIV-1
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;

  assign o_tick = (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (i_clr || o_tick) r_cnt <= '0;
    else                     r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, MSB first, one DATA_WIDTH-bit word per start.
// Ports:
//   clk, rst         system clock, async active-low reset
//   start, din       request + word to send (sampled only in IDLE)
//   dout, done       received word and its one-cycle valid pulse
//   busy             high from the accepting edge until back in IDLE
//   ss, sck, mosi    serial outputs (ss active-low, sck idles low)
//   miso             serial input, same clk domain as the slave
// CLK_DIV is the sck half-period in clk cycles and must be >= 2.
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = SPI_DATA_WIDTH,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  ss,
  output logic                  sck,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int BW = $clog2(DATA_WIDTH) + 1;

  spi_state_e            r_state, w_state;
  logic [DATA_WIDTH-1:0] r_tx, w_tx;
  logic [DATA_WIDTH-1:0] r_rx, w_rx;
  logic [DATA_WIDTH-1:0] r_dout, w_dout;
  logic [BW-1:0]         r_bit, w_bit;
  logic                  r_ss, w_ss;
  logic                  r_sck, w_sck;
  logic                  r_mosi, w_mosi;
  logic                  r_busy, w_busy;
  logic                  r_done, w_done;
  logic                  w_tick;

  // Divider held in reset while idle; every other state change happens on a
  // tick, where the divider wraps to 0 by itself.
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state == IDLE),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_rx    <= '0;
      r_dout  <= '0;
      r_bit   <= '0;
      r_ss    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_dout  <= w_dout;
      r_bit   <= w_bit;
      r_ss    <= w_ss;
      r_sck   <= w_sck;
      r_mosi  <= w_mosi;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  always_comb begin
    w_state = r_state;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_dout  = r_dout;
    w_bit   = r_bit;
    w_ss    = r_ss;
    w_sck   = r_sck;
    w_mosi  = r_mosi;
    w_busy  = r_busy;
    w_done  = 1'b0;
    case (r_state)
      IDLE: begin
        w_ss  = 1'b1;
        w_sck = 1'b0;
        if (start) begin
          w_tx    = din;
          w_ss    = 1'b0;
          w_mosi  = din[DATA_WIDTH-1];
          w_busy  = 1'b1;
          w_bit   = '0;
          w_state = LEAD;
        end
      end
      // First rising sck; mosi already holds the MSB for a full half-period.
      LEAD: begin
        if (w_tick) begin
          w_sck   = 1'b1;
          w_rx    = {r_rx[DATA_WIDTH-2:0], miso};
          w_bit   = r_bit + BW'(1);
          w_state = XFER;
        end
      end
      XFER: begin
        if (w_tick) begin
          if (!r_sck) begin
            w_sck = 1'b1;
            w_rx  = {r_rx[DATA_WIDTH-2:0], miso};
            w_bit = r_bit + BW'(1);
          end else begin
            w_sck = 1'b0;
            // After the last rising edge mosi keeps the LSB into TRAIL.
            if (r_bit == BW'(DATA_WIDTH)) begin
              w_state = TRAIL;
            end else begin
              w_tx   = {r_tx[DATA_WIDTH-2:0], 1'b0};
              w_mosi = r_tx[DATA_WIDTH-2];
            end
          end
        end
      end
      TRAIL: begin
        if (w_tick) begin
          w_ss    = 1'b1;
          w_mosi  = 1'b0;
          w_dout  = r_rx;
          w_done  = 1'b1;
          w_state = GAP;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_busy  = 1'b0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign dout = r_dout;
  assign busy = r_busy;
  assign done = r_done;
  assign ss   = r_ss;
  assign sck  = r_sck;
  assign mosi = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance at CLK_DIV=4 (loopback or a
// constant-high slave), one at CLK_DIV=2 in loopback.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic       st4 = 1'b0, st2 = 1'b0;
  logic [7:0] din4 = '0, din2 = '0;
  logic [7:0] dout4, dout2;
  logic       busy4, busy2, done4, done2, ss4, ss2, sck4, sck2, mosi4, mosi2;
  logic       miso4, miso2;
  logic       slv_ff = 1'b0;

  assign miso4 = slv_ff ? 1'b1 : mosi4;
  assign miso2 = mosi2;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .din(din4), .dout(dout4),
    .busy(busy4), .done(done4), .ss(ss4), .sck(sck4), .mosi(mosi4), .miso(miso4)
  );

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .din(din2), .dout(dout2),
    .busy(busy2), .done(done2), .ss(ss2), .sck(sck2), .mosi(mosi2), .miso(miso2)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // negedge monitors (outputs sampled half a cycle after the active edge)
  int         rise4 = 0, sslow4 = 0, ndone4 = 0, ss_rise4 = 0, gap4 = 0, bfall4 = 0;
  logic [7:0] slv_rx4 = '0;
  logic       p_sck4 = 1'b0, p_ss4 = 1'b1, p_busy4 = 1'b0;
  always @(negedge clk) begin
    if (sck4 && !p_sck4) begin
      rise4++;
      slv_rx4 = {slv_rx4[6:0], mosi4};
    end
    if (!ss4) sslow4++;
    if (ss4 && !p_ss4) ss_rise4 = cyc;
    if (!ss4 && p_ss4) gap4 = cyc - ss_rise4;
    if (done4) ndone4++;
    if (!busy4 && p_busy4) bfall4 = cyc;
    p_sck4  = sck4;
    p_ss4   = ss4;
    p_busy4 = busy4;
  end

  int         last_r2 = 0, prev_r2 = 0;
  logic [7:0] cap2 = '0;
  logic       p_sck2 = 1'b0;
  always @(negedge clk) begin
    if (sck2 && !p_sck2) begin
      prev_r2 = last_r2;
      last_r2 = cyc;
      cap2    = {cap2[6:0], mosi2};
    end
    p_sck2 = sck2;
  end

  task automatic wait_done(input bit sel, output int t);
    t = -1000;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sel ? done2 : done4) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy4 && !busy2) break;
    end
  endtask

  // start pulse for one edge on dut4; returns accepting edge number
  task automatic go4(input logic [7:0] d, output int t0);
    @(negedge clk);
    din4 = d;
    st4  = 1'b1;
    t0   = cyc + 1;
    @(negedge clk);
    st4  = 1'b0;
  endtask

  int t0, ta, tb, r0, s0, n0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ss",   ss4,   1'b1);
    chk("rst_sck",  sck4,  1'b0);
    chk("rst_mosi", mosi4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_dout", dout4, 8'h00);
    chk("rst_ss2",  ss2,   1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // loopback A5
    r0 = rise4; s0 = sslow4;
    go4(8'hA5, t0);
    wait_done(1'b0, ta);
    chk("lb_lat",   ta - t0, 68);
    chk("lb_dout",  dout4, 8'hA5);
    wait_idle();
    chk("lb_rises", rise4 - r0, 8);
    chk("lb_sslow", sslow4 - s0, 68);

    // constant-high slave, slave side sees 3C
    slv_ff = 1'b1;
    go4(8'h3C, t0);
    wait_done(1'b0, ta);
    chk("slv_mdout", dout4, 8'hFF);
    chk("slv_sdout", slv_rx4, 8'h3C);
    wait_idle();
    slv_ff = 1'b0;

    // CLK_DIV=2, din=01
    @(negedge clk);
    din2 = 8'h01;
    st2  = 1'b1;
    t0   = cyc + 1;
    @(negedge clk);
    st2  = 1'b0;
    wait_done(1'b1, ta);
    chk("d2_lat",    ta - t0, 34);
    chk("d2_dout",   dout2, 8'h01);
    chk("d2_mosi",   cap2, 8'h01);
    chk("d2_sckper", last_r2 - prev_r2, 4);
    wait_idle();

    // starts during a transfer are dropped
    n0 = ndone4;
    go4(8'h96, t0);
    while (cyc < t0 + 9) @(negedge clk);
    din4 = 8'h11; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    while (cyc < t0 + 39) @(negedge clk);
    st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    while (cyc < t0 + 110) @(negedge clk);
    chk("ign_ndone", ndone4 - n0, 1);
    chk("ign_bfall", bfall4 - t0, 72);
    chk("ign_dout",  dout4, 8'h96);
    chk("ign_busy",  busy4, 1'b0);

    // start held high: back-to-back 55 then AA
    @(negedge clk);
    din4 = 8'h55;
    st4  = 1'b1;
    t0   = cyc + 1;
    wait_done(1'b0, ta);
    chk("b2b_lat",   ta - t0, 68);
    chk("b2b_dout1", dout4, 8'h55);
    din4 = 8'hAA;
    wait_done(1'b0, tb);
    st4 = 1'b0;
    chk("b2b_per",   tb - ta, 73);
    chk("b2b_dout2", dout4, 8'hAA);
    chk("b2b_gap",   gap4, 5);
    wait_idle();

    // async reset mid-transfer
    n0 = ndone4;
    go4(8'hC3, t0);
    while (cyc < t0 + 30) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_ss",   ss4,   1'b1);
    chk("ar_sck",  sck4,  1'b0);
    chk("ar_busy", busy4, 1'b0);
    repeat (80) @(negedge clk);
    chk("ar_ndone", ndone4 - n0, 0);
    chk("ar_dout",  dout4, 8'h00);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    go4(8'h3C, t0);
    wait_done(1'b0, ta);
    chk("ar_lat2",  ta - t0, 68);
    chk("ar_dout2", dout4, 8'h3C);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
